// File: rtl/sc_togglesched_pkg.sv
// Shared types and defaults for the toggle scheduler: FSM state encoding and
// parameter defaults used by the top, the prescaler and the bus interface.
package sc_togglesched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        RUN    = 2'd2,
        DISARM = 2'd3
    } schedState_t;

    localparam int unsigned DEFAULT_PRESCALE_DIV = 50000;
    localparam int unsigned DEFAULT_SPEED_W      = 4;
    localparam int unsigned DEFAULT_CNT_W        = 8;
    localparam int unsigned DEFAULT_MAX_PULSES   = 16;

endpackage

// File: rtl/sc_statemachine_toggle_scheduler_if.sv
// Button/switch and FLAG/status bundle between the board controls, the
// toggle scheduler (slave) and whatever drives and observes it (master).
interface sc_statemachine_toggle_scheduler_if
    import sc_togglesched_pkg::*;
#(
    parameter int unsigned SPEED_W = DEFAULT_SPEED_W,
    parameter int unsigned CNT_W   = DEFAULT_CNT_W
);
    logic               SC_TOGGLESCHED_startButton_InLow;
    logic [SPEED_W-1:0] SC_TOGGLESCHED_speed_InBUS;
    logic               SC_TOGGLESCHED_FLAG_OutLow;
    logic               SC_TOGGLESCHED_Running_Out;
    logic [CNT_W-1:0]   SC_TOGGLESCHED_PulseCount_OutBUS;
    logic               SC_TOGGLESCHED_Done_Out;

    modport master (
        output SC_TOGGLESCHED_startButton_InLow,
        output SC_TOGGLESCHED_speed_InBUS,
        input  SC_TOGGLESCHED_FLAG_OutLow,
        input  SC_TOGGLESCHED_Running_Out,
        input  SC_TOGGLESCHED_PulseCount_OutBUS,
        input  SC_TOGGLESCHED_Done_Out
    );

    modport slave (
        input  SC_TOGGLESCHED_startButton_InLow,
        input  SC_TOGGLESCHED_speed_InBUS,
        output SC_TOGGLESCHED_FLAG_OutLow,
        output SC_TOGGLESCHED_Running_Out,
        output SC_TOGGLESCHED_PulseCount_OutBUS,
        output SC_TOGGLESCHED_Done_Out
    );

endinterface

// File: rtl/sc_tick_prescaler.sv
// Base-tick generator: one-clock tick every DIV enabled clocks; the count is
// held at zero whenever enable is low so each run starts from a full period.
module sc_tick_prescaler
    import sc_togglesched_pkg::*;
#(
    parameter int unsigned DIV = DEFAULT_PRESCALE_DIV
) (
    input  logic clock,
    input  logic resetInLow,
    input  logic enable,
    output logic tick
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    assign tick = enable && (count == CW'(DIV - 1));

    always_ff @(posedge clock or negedge resetInLow) begin
        if (!resetInLow) begin
            count <= '0;
        end else if (!enable || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sc_statemachine_toggle_scheduler.sv
// Run/stop sequencer issuing periodic one-clock active-low FLAG pulses for the
// toggle FSM. Optional auto-stop after MAX_PULSES: SC_TOGGLESCHED_AUTOSTOP_EN.
module sc_statemachine_toggle_scheduler
    import sc_togglesched_pkg::*;
#(
    parameter int unsigned PRESCALE_DIV = DEFAULT_PRESCALE_DIV,
    parameter int unsigned SPEED_W      = DEFAULT_SPEED_W,
    parameter int unsigned CNT_W        = DEFAULT_CNT_W,
    parameter int unsigned MAX_PULSES   = DEFAULT_MAX_PULSES
) (
    input logic SC_TOGGLESCHED_CLOCK_50,
    input logic SC_TOGGLESCHED_RESET_InLow,
    sc_statemachine_toggle_scheduler_if.slave schedBus
);
    if (PRESCALE_DIV < 4 || MAX_PULSES < 1) begin : gBadConfig
        $error("sc_statemachine_toggle_scheduler: PRESCALE_DIV must be >= 4 and MAX_PULSES >= 1");
    end

    schedState_t        state;
    schedState_t        stateNext;
    logic               runningReg;
    logic               flagReg;
    logic               doneReg;
    logic [SPEED_W-1:0] halfCnt;
    logic [CNT_W-1:0]   pulseCount;
    logic               runStart;
    logic               tick;
    logic               fire;
    logic               autostopHit;
    logic               needRelease;
    logic               startBtn;

    assign startBtn = schedBus.SC_TOGGLESCHED_startButton_InLow;

    sc_tick_prescaler #(
        .DIV(PRESCALE_DIV)
    ) uPrescaler (
        .clock     (SC_TOGGLESCHED_CLOCK_50),
        .resetInLow(SC_TOGGLESCHED_RESET_InLow),
        .enable    (state == RUN),
        .tick      (tick)
    );

    // >= rather than == so a speed lowered below halfCnt fires on the next tick
    assign fire = tick && (halfCnt >= schedBus.SC_TOGGLESCHED_speed_InBUS);

`ifdef SC_TOGGLESCHED_AUTOSTOP_EN
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MAX_PULSES - 1);

    assign autostopHit = fire && (pulseCount == LAST_COUNT);

    // After auto-stop a still-held button must be released before a new start
    always_ff @(posedge SC_TOGGLESCHED_CLOCK_50 or negedge SC_TOGGLESCHED_RESET_InLow) begin
        if (!SC_TOGGLESCHED_RESET_InLow) begin
            needRelease <= 1'b0;
        end else if (autostopHit) begin
            needRelease <= 1'b1;
        end else if (startBtn) begin
            needRelease <= 1'b0;
        end
    end
`else
    assign autostopHit = 1'b0;
    assign needRelease = 1'b0;
`endif

    always_ff @(posedge SC_TOGGLESCHED_CLOCK_50 or negedge SC_TOGGLESCHED_RESET_InLow) begin
        if (!SC_TOGGLESCHED_RESET_InLow) begin
            state      <= IDLE;
            runningReg <= 1'b0;
        end else begin
            state      <= stateNext;
            runningReg <= (stateNext == RUN);
        end
    end

    always_comb begin
        stateNext = state;
        runStart  = 1'b0;
        case (state)
            IDLE: begin
                if (!startBtn && !needRelease) begin
                    stateNext = ARM;
                end
            end
            ARM: begin
                if (startBtn) begin
                    stateNext = RUN;
                    runStart  = 1'b1;
                end
            end
            RUN: begin
                if (autostopHit) begin
                    stateNext = IDLE;
                end else if (!startBtn) begin
                    stateNext = DISARM;
                end
            end
            DISARM: begin
                if (startBtn) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Ticks only occur in RUN, so they never coincide with the ARM->RUN clear
    always_ff @(posedge SC_TOGGLESCHED_CLOCK_50 or negedge SC_TOGGLESCHED_RESET_InLow) begin
        if (!SC_TOGGLESCHED_RESET_InLow) begin
            halfCnt    <= '0;
            pulseCount <= '0;
            flagReg    <= 1'b1;
            doneReg    <= 1'b0;
        end else begin
            flagReg <= ~fire;
            doneReg <= autostopHit;
            if (runStart) begin
                halfCnt    <= '0;
                pulseCount <= '0;
            end else if (tick) begin
                if (fire) begin
                    halfCnt    <= '0;
                    pulseCount <= pulseCount + 1'b1;
                end else begin
                    halfCnt <= halfCnt + 1'b1;
                end
            end
        end
    end

    assign schedBus.SC_TOGGLESCHED_FLAG_OutLow       = flagReg;
    assign schedBus.SC_TOGGLESCHED_Running_Out       = runningReg;
    assign schedBus.SC_TOGGLESCHED_PulseCount_OutBUS = pulseCount;
    assign schedBus.SC_TOGGLESCHED_Done_Out          = doneReg;

endmodule
